gun_hit_detector: RTL and testbench
===================================

GUN_HIT_DETECTOR -- requirements
Module: gun_hit_detector

Interface
REQ-001 SHALL have parameters: DEBOUNCE_CYCLES, default 65000, trigger stable-cycles to accept a level; HIT_MIN_CYCLES, default 16, consecutive lit cycles that count as a hit.
REQ-002 SHALL have ports: clk  in  1  system clock, the only clock; all logic on its rising edge.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: trigger  in  1  raw gun trigger, asynchronous, 1 = pulled.
REQ-005 SHALL have ports: light  in  1  raw photodiode comparator, asynchronous, 1 = bright pixel seen.
REQ-006 SHALL have ports: new_frame  in  1  one-cycle pulse at start of each video frame.
REQ-007 SHALL have ports: gun_is_connected  in  1  gun present.
REQ-008 SHALL have ports: shot_fired  out  1  one-cycle pulse per accepted shot; drives the target-flash drawer.
REQ-009 SHALL have ports: duck_hit  out  1  level; 1 from hit decision until next accepted shot.
REQ-010 SHALL have ports: miss  out  1  one-cycle pulse when a window closes without a hit.
REQ-011 SHALL have ports: busy  out  1  1 in every state except IDLE.

Function
REQ-012 trigger and light SHALL each pass a 2-flop synchroniser before use.
REQ-013 Synchronised trigger SHALL be debounced: debounced level changes only after the input differs from it for DEBOUNCE_CYCLES consecutive cycles; counter clears on any agreeing sample.
REQ-014 FSM states SHALL be IDLE, SKIP, WINDOW.
REQ-015 IDLE: on debounced-trigger rising edge with gun_is_connected=1, SHALL pulse shot_fired, clear duck_hit in the same cycle, go to SKIP.
REQ-016 SKIP: SHALL ignore light and go to WINDOW on the next new_frame. This discards the partial frame in which the shot occurred.
REQ-017 WINDOW: SHALL count new_frame pulses in a 4-bit counter. The new_frame that entered WINDOW is not counted. On the WINDOW_FRAMES-th counted pulse, SHALL return to IDLE.
REQ-018 WINDOW: SHALL count consecutive cycles with synchronised light=1, saturating at HIT_MIN_CYCLES. The counter clears on light=0 and on every new_frame.
REQ-019 When the light counter reaches HIT_MIN_CYCLES in WINDOW, SHALL set duck_hit the next cycle. SHALL stay in WINDOW until the frame count completes, so no re-trigger lands mid-flash.
REQ-020 On WINDOW exit with duck_hit=0, SHALL pulse miss for one cycle, coincident with the IDLE transition.
REQ-021 Trigger edges outside IDLE SHALL be ignored; they are not queued. A trigger still held on return to IDLE SHALL NOT fire; a new rising edge is required.
REQ-022 gun_is_connected=0 in SKIP or WINDOW SHALL abort to IDLE next cycle, with no miss, duck_hit unchanged.
REQ-023 new_frame and a light-threshold crossing in the same cycle: the frame count SHALL apply and the hit SHALL NOT register, because the counter clears (REQ-018).
REQ-024 Latency SHALL be: trigger pin to shot_fired = 2 sync + DEBOUNCE_CYCLES + 1 edge-detect cycles.

Reset
REQ-025 While rst=0, SHALL hold: state IDLE; shot_fired, duck_hit, miss, busy 0; all counters, synchronisers and debounced level 0.
REQ-026 Reset asserted mid-window SHALL abort immediately with no miss pulse. After release, a trigger already held SHALL NOT fire until released and re-pulled.

Structure
REQ-027 Shared package SHALL hold TARGET_FRAMES=10, WINDOW_FRAMES=TARGET_FRAMES-2=8 and the FSM state enum. The flash drawer SHALL use the same TARGET_FRAMES so window and flash stay aligned.
REQ-028 Debounce SHALL be a sub-module, debouncer: synchroniser plus stability counter, parameter DEBOUNCE_CYCLES. The light path SHALL use only the synchroniser.
REQ-029 Implementation SHALL be 120-400 lines total. All registers SHALL be on clk, async clear from rst.

Verification (bench with DEBOUNCE_CYCLES=4, HIT_MIN_CYCLES=3, new_frame every 100 cycles)
REQ-030 Bench SHALL cover a clean shot and hit:
- Stimulus: trigger high for 10 cycles; light high for 5 cycles in the 2nd window frame.
- Response: one shot_fired pulse 7 cycles after the trigger edge; duck_hit=1 about 3 cycles after light+2; busy until the 8th counted new_frame; no miss.
REQ-031 Bench SHALL cover a miss:
- Stimulus: shot with light never high.
- Response: miss pulse exactly at the 8th counted new_frame; duck_hit stays 0.
REQ-032 Bench SHALL cover bounce and retrigger rejection:
- Stimulus: trigger toggling every 2 cycles for 20 cycles, then a second pull during WINDOW.
- Response: no shot_fired during the toggling; the second pull is ignored.
REQ-033 Bench SHALL cover short flicker and light in the skipped frame:
- Stimulus: light pulses of 2 cycles in WINDOW; light high for 10 cycles in SKIP.
- Response: no hit.
REQ-034 Bench SHALL cover disconnect and reset mid-window:
- Stimulus: gun_is_connected 0 at frame 3; separately, rst=0 at frame 4.
- Response: immediate IDLE; no miss; all outputs 0 after reset.

Source files
------------

// File: rtl/gun_hit_detector_pkg.sv
// Shared constants and FSM state type for the light-gun hit detector.
// The target-flash drawer imports TARGET_FRAMES from here so the window and the flash stay aligned.
package gun_hit_detector_pkg;

    localparam int unsigned TARGET_FRAMES = 10;
    // The window skips the shot frame and ends before the flash finishes.
    localparam int unsigned WINDOW_FRAMES = TARGET_FRAMES - 2;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSkip   = 2'd1,
        StWindow = 2'd2
    } state_e;

    // Value of the 4-bit frame counter on the last pulse before the window closes.
    function automatic logic [3:0] last_frame_count();
        return 4'(WINDOW_FRAMES - 1);
    endfunction

endpackage

// File: rtl/gun_hit_detector_debouncer.sv
// Two-flop synchroniser followed by a stability counter. The debounced level follows the
// synchronised input only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 65000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync_out,
    output logic level
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], din};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // Any sample agreeing with the current level restarts the stability count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign sync_out = sync_q[1];
    assign level    = level_q;

endmodule

// File: rtl/gun_hit_detector.sv
// Light-gun shot controller: debounces the trigger, skips the shot frame, then watches the
// photodiode over a fixed number of frames and reports a hit or a miss.
module gun_hit_detector
    import gun_hit_detector_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 65000,
    parameter int unsigned HIT_MIN_CYCLES  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger,
    input  logic light,
    input  logic new_frame,
    input  logic gun_is_connected,
    output logic shot_fired,
    output logic duck_hit,
    output logic miss,
    output logic busy
);

    localparam int unsigned LW = $clog2(HIT_MIN_CYCLES + 1);

    state_e        state_q, state_d;
    logic [3:0]    frame_cnt_q, frame_cnt_d;
    logic [LW-1:0] light_cnt_q, light_cnt_d;
    logic [1:0]    light_sync_q;
    logic [1:0]    fill_q, fill_d;
    logic          armed_q, armed_d;
    logic          trig_prev_q;
    logic          shot_q, shot_d;
    logic          duck_hit_q, duck_hit_d;
    logic          miss_q, miss_d;

    logic trig_sync;
    logic trig_level;
    logic trig_rise;
    logic light_s;
    logic hit_now;

    debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_trigger_debouncer (
        .clk      (clk),
        .rst      (rst),
        .din      (trigger),
        .sync_out (trig_sync),
        .level    (trig_level)
    );

    assign light_s   = light_sync_q[1];
    assign trig_rise = trig_level & ~trig_prev_q;
    assign hit_now   = (light_cnt_q == LW'(HIT_MIN_CYCLES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            frame_cnt_q  <= 4'd0;
            light_cnt_q  <= '0;
            light_sync_q <= 2'b00;
            fill_q       <= 2'd0;
            armed_q      <= 1'b0;
            trig_prev_q  <= 1'b0;
            shot_q       <= 1'b0;
            duck_hit_q   <= 1'b0;
            miss_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            light_cnt_q  <= light_cnt_d;
            light_sync_q <= {light_sync_q[0], light};
            fill_q       <= fill_d;
            armed_q      <= armed_d;
            trig_prev_q  <= trig_level;
            shot_q       <= shot_d;
            duck_hit_q   <= duck_hit_d;
            miss_q       <= miss_d;
        end
    end

    // After reset the trigger must be seen released (once the synchroniser holds real samples)
    // before any rising edge may fire, so a trigger held through reset stays inert.
    always_comb begin
        fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
        armed_d = armed_q | ((fill_q == 2'd2) & ~trig_sync);
    end

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        light_cnt_d = light_cnt_q;
        shot_d      = 1'b0;
        miss_d      = 1'b0;
        duck_hit_d  = duck_hit_q;

        unique case (state_q)
            StIdle: begin
                if (trig_rise && armed_q && gun_is_connected) begin
                    shot_d     = 1'b1;
                    duck_hit_d = 1'b0;
                    state_d    = StSkip;
                end
            end

            StSkip: begin
                if (!gun_is_connected) begin
                    state_d = StIdle;
                end else if (new_frame) begin
                    state_d     = StWindow;
                    frame_cnt_d = 4'd0;
                    light_cnt_d = '0;
                end
            end

            StWindow: begin
                if (!gun_is_connected) begin
                    state_d     = StIdle;
                    light_cnt_d = '0;
                end else begin
                    if (hit_now) begin
                        duck_hit_d = 1'b1;
                    end
                    // A frame boundary always wins over a threshold crossing in the same cycle.
                    if (new_frame) begin
                        light_cnt_d = '0;
                        frame_cnt_d = frame_cnt_q + 4'd1;
                        if (frame_cnt_q == last_frame_count()) begin
                            state_d = StIdle;
                            miss_d  = ~(duck_hit_q | hit_now);
                        end
                    end else if (light_s) begin
                        if (!hit_now) begin
                            light_cnt_d = light_cnt_q + LW'(1);
                        end
                    end else begin
                        light_cnt_d = '0;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign shot_fired = shot_q;
    assign duck_hit   = duck_hit_q;
    assign miss       = miss_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_gun_hit_detector.sv
// Randomised scenario bench for gun_hit_detector; expected event times come from timing
// arithmetic on the pin-level stimulus (sync delay, debounce length, frame grid).
module tb_gun_hit_detector;

    localparam int DEB = 4;
    localparam int HIT = 3;
    localparam int FP  = 100;
    localparam int WF  = 8;
    localparam int SHOT_LAT = 2 + DEB + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic trigger = 1'b0;
    logic light = 1'b0;
    logic new_frame = 1'b0;
    logic gun_is_connected = 1'b1;
    logic shot_fired, duck_hit, miss, busy;

    int n_cmp = 0;
    int n_err = 0;
    int edge_n = 0;

    int shot_cnt = 0;
    int shot_edge = -1;
    int miss_cnt = 0;
    int miss_edge = -1;
    int hit_edge = -1;
    int busy_fall = -1;
    logic dh_prev = 1'b0;
    logic busy_prev = 1'b0;

    gun_hit_detector #(
        .DEBOUNCE_CYCLES(DEB),
        .HIT_MIN_CYCLES (HIT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .trigger          (trigger),
        .light            (light),
        .new_frame        (new_frame),
        .gun_is_connected (gun_is_connected),
        .shot_fired       (shot_fired),
        .duck_hit         (duck_hit),
        .miss             (miss),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Output event log, sampled on the falling edge.
    always @(negedge clk) begin
        if (shot_fired) begin
            shot_cnt  <= shot_cnt + 1;
            shot_edge <= edge_n;
        end
        if (miss) begin
            miss_cnt  <= miss_cnt + 1;
            miss_edge <= edge_n;
        end
        if (duck_hit && !dh_prev) hit_edge <= edge_n;
        if (!busy && busy_prev) busy_fall <= edge_n;
        dh_prev   <= duck_hit;
        busy_prev <= busy;
    end

    // new_frame is sampled high on every edge that is a multiple of FP.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            new_frame = ((edge_n + 1) % FP == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int e);
        while (edge_n < e) tick(1);
    endtask

    task automatic wait_phase(input int p);
        tick(1);
        while (edge_n % FP != p) tick(1);
    endtask

    function automatic int first_frame_after(input int e);
        return (e / FP + 1) * FP;
    endfunction

    // Light driven after edge l0 for n cycles is seen by the detector on edges l0+3..l0+n+2.
    // A hit needs HIT such edges in a row inside the window with no frame edge among them;
    // duck_hit then appears one edge later.
    function automatic int expect_hit(input int l0, input int n, input int wstart, input int wend);
        int run;
        run = 0;
        for (int e = l0 + 3; e <= l0 + n + 2; e++) begin
            if (e <= wstart || e > wend || e % FP == 0) begin
                run = 0;
            end else begin
                run++;
                if (run == HIT) return e + 1;
            end
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        trigger = 1'b1;
        light = 1'b1;
        tick(5);
        n_cmp++; if (shot_fired !== 1'b0) begin n_err++; $display("FAIL reset_shot got %b want 0", shot_fired); end
        n_cmp++; if (duck_hit !== 1'b0) begin n_err++; $display("FAIL reset_duck_hit got %b want 0", duck_hit); end
        n_cmp++; if (miss !== 1'b0) begin n_err++; $display("FAIL reset_miss got %b want 0", miss); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        trigger = 1'b0;
        light = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(30);
        n_cmp++; if (shot_cnt !== 0) begin n_err++; $display("FAIL reset_no_shot got %0d want 0", shot_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_hit();
        int t0, f1, l0, n, eh, s0, m0;
        wait_phase($urandom_range(60, 10));
        s0 = shot_cnt;
        m0 = miss_cnt;
        t0 = edge_n;
        trigger = 1'b1;
        tick(10);
        trigger = 1'b0;
        f1 = first_frame_after(t0 + SHOT_LAT);
        n = $urandom_range(15, 5);
        wait_until(f1 + FP + $urandom_range(70, 10));
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL hit_busy got %b want 1", busy); end
        l0 = edge_n;
        light = 1'b1;
        tick(n);
        light = 1'b0;
        eh = expect_hit(l0, n, f1, f1 + WF * FP);
        wait_until(f1 + WF * FP + 5);
        n_cmp++; if (shot_cnt - s0 !== 1) begin n_err++; $display("FAIL hit_shot_count got %0d want 1", shot_cnt - s0); end
        n_cmp++; if (shot_edge !== t0 + SHOT_LAT) begin n_err++; $display("FAIL hit_shot_edge got %0d want %0d", shot_edge, t0 + SHOT_LAT); end
        n_cmp++; if (hit_edge !== eh) begin n_err++; $display("FAIL hit_edge got %0d want %0d", hit_edge, eh); end
        n_cmp++; if (busy_fall !== f1 + WF * FP) begin n_err++; $display("FAIL hit_busy_end got %0d want %0d", busy_fall, f1 + WF * FP); end
        n_cmp++; if (miss_cnt - m0 !== 0) begin n_err++; $display("FAIL hit_no_miss got %0d want 0", miss_cnt - m0); end
        n_cmp++; if (duck_hit !== 1'b1) begin n_err++; $display("FAIL hit_level got %b want 1", duck_hit); end
    endtask

    task automatic test_miss();
        int t0, f1, m0;
        wait_phase($urandom_range(60, 10));
        m0 = miss_cnt;
        t0 = edge_n;
        trigger = 1'b1;
        tick(10);
        trigger = 1'b0;
        f1 = first_frame_after(t0 + SHOT_LAT);
        tick(5);
        n_cmp++; if (duck_hit !== 1'b0) begin n_err++; $display("FAIL miss_cleared got %b want 0", duck_hit); end
        wait_until(f1 + WF * FP + 5);
        n_cmp++; if (miss_cnt - m0 !== 1) begin n_err++; $display("FAIL miss_count got %0d want 1", miss_cnt - m0); end
        n_cmp++; if (miss_edge !== f1 + WF * FP) begin n_err++; $display("FAIL miss_edge got %0d want %0d", miss_edge, f1 + WF * FP); end
        n_cmp++; if (busy_fall !== f1 + WF * FP) begin n_err++; $display("FAIL miss_busy_end got %0d want %0d", busy_fall, f1 + WF * FP); end
        n_cmp++; if (duck_hit !== 1'b0) begin n_err++; $display("FAIL miss_duck_hit got %b want 0", duck_hit); end
    endtask

    task automatic test_back_to_back();
        int t0, f1, s0, m0;
        wait_phase($urandom_range(40, 5));
        s0 = shot_cnt;
        for (int i = 0; i < 20; i++) begin
            trigger = ((i / 2) % 2 == 0);
            tick(1);
        end
        trigger = 1'b0;
        tick(10);
        n_cmp++; if (shot_cnt - s0 !== 0) begin n_err++; $display("FAIL bounce_shots got %0d want 0", shot_cnt - s0); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bounce_busy got %b want 0", busy); end
        m0 = miss_cnt;
        t0 = edge_n;
        trigger = 1'b1;
        tick(10);
        trigger = 1'b0;
        f1 = first_frame_after(t0 + SHOT_LAT);
        // Second pull inside the window, held past the return to idle.
        wait_until(f1 + FP + $urandom_range(80, 20));
        trigger = 1'b1;
        wait_until(f1 + WF * FP + 50);
        n_cmp++; if (shot_cnt - s0 !== 1) begin n_err++; $display("FAIL retrigger_count got %0d want 1", shot_cnt - s0); end
        n_cmp++; if (shot_edge !== t0 + SHOT_LAT) begin n_err++; $display("FAIL retrigger_edge got %0d want %0d", shot_edge, t0 + SHOT_LAT); end
        n_cmp++; if (miss_edge !== f1 + WF * FP) begin n_err++; $display("FAIL retrigger_miss_edge got %0d want %0d", miss_edge, f1 + WF * FP); end
        trigger = 1'b0;
        tick(40);
        n_cmp++; if (shot_cnt - s0 !== 1) begin n_err++; $display("FAIL held_release_count got %0d want 1", shot_cnt - s0); end
        n_cmp++; if (miss_cnt - m0 !== 1) begin n_err++; $display("FAIL retrigger_miss_count got %0d want 1", miss_cnt - m0); end
    endtask

    task automatic test_flicker_skip();
        int t0, f1, l0, m0;
        logic exp_dh;
        exp_dh = 1'b0;
        wait_phase(5);
        m0 = miss_cnt;
        t0 = edge_n;
        trigger = 1'b1;
        tick(10);
        trigger = 1'b0;
        f1 = first_frame_after(t0 + SHOT_LAT);
        wait_until(f1 - FP + 40);
        l0 = edge_n;
        light = 1'b1;
        tick(10);
        light = 1'b0;
        if (expect_hit(l0, 10, f1, f1 + WF * FP) != -1) exp_dh = 1'b1;
        wait_until(f1 + 20);
        for (int i = 0; i < 8; i++) begin
            l0 = edge_n;
            light = 1'b1;
            tick(2);
            light = 1'b0;
            if (expect_hit(l0, 2, f1, f1 + WF * FP) != -1) exp_dh = 1'b1;
            tick($urandom_range(5, 1));
        end
        // Third bright sample lands on the frame edge, so the count restarts there.
        wait_until(f1 + 2 * FP - 5);
        l0 = edge_n;
        light = 1'b1;
        tick(5);
        light = 1'b0;
        if (expect_hit(l0, 5, f1, f1 + WF * FP) != -1) exp_dh = 1'b1;
        wait_until(f1 + WF * FP + 5);
        n_cmp++; if (duck_hit !== exp_dh) begin n_err++; $display("FAIL flicker_duck_hit got %b want %b", duck_hit, exp_dh); end
        n_cmp++; if (miss_cnt - m0 !== (exp_dh ? 0 : 1)) begin n_err++; $display("FAIL flicker_miss_count got %0d want %0d", miss_cnt - m0, exp_dh ? 0 : 1); end
        n_cmp++; if (miss_edge !== f1 + WF * FP) begin n_err++; $display("FAIL flicker_miss_edge got %0d want %0d", miss_edge, f1 + WF * FP); end
    endtask

    task automatic test_disconnect();
        int t0, f1, l0, eh, s0, m0;
        wait_phase($urandom_range(50, 10));
        s0 = shot_cnt;
        m0 = miss_cnt;
        t0 = edge_n;
        trigger = 1'b1;
        tick(10);
        trigger = 1'b0;
        f1 = first_frame_after(t0 + SHOT_LAT);
        wait_until(f1 + 30);
        l0 = edge_n;
        light = 1'b1;
        tick(6);
        light = 1'b0;
        eh = expect_hit(l0, 6, f1, f1 + WF * FP);
        wait_until(f1 + 3 * FP + $urandom_range(60, 10));
        n_cmp++; if (hit_edge !== eh) begin n_err++; $display("FAIL disc_hit_edge got %0d want %0d", hit_edge, eh); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL disc_busy_before got %b want 1", busy); end
        gun_is_connected = 1'b0;
        tick(1);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL disc_abort got %b want 0", busy); end
        n_cmp++; if (duck_hit !== (eh != -1)) begin n_err++; $display("FAIL disc_duck_hit got %b want %b", duck_hit, eh != -1); end
        trigger = 1'b1;
        tick(10);
        trigger = 1'b0;
        tick(30);
        gun_is_connected = 1'b1;
        tick(20);
        n_cmp++; if (shot_cnt - s0 !== 1) begin n_err++; $display("FAIL disc_shots got %0d want 1", shot_cnt - s0); end
        n_cmp++; if (miss_cnt - m0 !== 0) begin n_err++; $display("FAIL disc_miss got %0d want 0", miss_cnt - m0); end
    endtask

    task automatic test_reset_mid_window();
        int t0, f1, s0, m0;
        wait_phase($urandom_range(50, 10));
        s0 = shot_cnt;
        m0 = miss_cnt;
        trigger = 1'b1;
        t0 = edge_n;
        f1 = first_frame_after(t0 + SHOT_LAT);
        wait_until(f1 + 4 * FP + $urandom_range(60, 10));
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_cmp++; if (shot_fired !== 1'b0) begin n_err++; $display("FAIL rstmid_shot got %b want 0", shot_fired); end
        n_cmp++; if (duck_hit !== 1'b0) begin n_err++; $display("FAIL rstmid_duck_hit got %b want 0", duck_hit); end
        n_cmp++; if (miss !== 1'b0) begin n_err++; $display("FAIL rstmid_miss got %b want 0", miss); end
        tick(3);
        rst = 1'b1;
        tick(60);
        n_cmp++; if (shot_cnt - s0 !== 1) begin n_err++; $display("FAIL rstmid_held_shots got %0d want 1", shot_cnt - s0); end
        n_cmp++; if (miss_cnt - m0 !== 0) begin n_err++; $display("FAIL rstmid_no_miss got %0d want 0", miss_cnt - m0); end
        trigger = 1'b0;
        tick(20);
        t0 = edge_n;
        trigger = 1'b1;
        tick(10);
        trigger = 1'b0;
        f1 = first_frame_after(t0 + SHOT_LAT);
        tick(5);
        n_cmp++; if (shot_cnt - s0 !== 2) begin n_err++; $display("FAIL rstmid_repull_count got %0d want 2", shot_cnt - s0); end
        n_cmp++; if (shot_edge !== t0 + SHOT_LAT) begin n_err++; $display("FAIL rstmid_repull_edge got %0d want %0d", shot_edge, t0 + SHOT_LAT); end
        wait_until(f1 + WF * FP + 5);
        n_cmp++; if (miss_edge !== f1 + WF * FP) begin n_err++; $display("FAIL rstmid_final_miss got %0d want %0d", miss_edge, f1 + WF * FP); end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_hit();
        test_miss();
        test_back_to_back();
        test_flicker_skip();
        test_disconnect();
        test_reset_mid_window();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
